// File: rtl/inst_loader.sv
// inst_loader: length-prefixed byte-stream loader that assembles opcodes and
// drives the instruction-buffer write port. write_inst_en doubles as the core
// pipeline hold, so it stays high for the whole load session.
module inst_loader #(
    parameter int unsigned OPCODE_WIDTH = 25,
    parameter int unsigned OPCODE_COUNT = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [7:0]                      in_data,
    output logic                            in_ready,
    output logic                            write_inst_en,
    output logic [OPCODE_WIDTH-1:0]         write_inst_data,
    output logic [$clog2(OPCODE_COUNT)-1:0] write_inst_addr,
    output logic                            busy,
    output logic                            load_done,
    output logic                            load_error
);

    localparam int unsigned BPW = (OPCODE_WIDTH + 7) / 8;
    localparam int unsigned AW  = $clog2(OPCODE_COUNT);
    localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t            state;
    logic [BCW-1:0]    byte_cnt;
    logic [AW-1:0]     last_idx;

    logic              accept_c;
    logic              hdr_ok_c;
    logic [OPCODE_WIDTH-1:0] merged_c;

    // Handshake uses the registered ready, so nothing combinational reaches outputs.
    assign accept_c = in_valid & in_ready;
    assign hdr_ok_c = (in_data != 8'd0) && (32'(in_data) <= OPCODE_COUNT);

    // Current word with the incoming byte dropped into its lane; bits past the opcode width fall away.
    always_comb begin
        merged_c = write_inst_data;
        for (int unsigned b = 0; b < OPCODE_WIDTH; b++) begin
            if (BCW'(b / 8) == byte_cnt) begin
                merged_c[b] = in_data[3'(b % 8)];
            end
        end
    end

    // Load session state machine; write_inst_addr is the word index and write_inst_data the word register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            byte_cnt        <= '0;
            last_idx        <= '0;
            in_ready        <= 1'b0;
            write_inst_en   <= 1'b0;
            write_inst_data <= '0;
            write_inst_addr <= '0;
            busy            <= 1'b0;
            load_done       <= 1'b0;
            load_error      <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        if (hdr_ok_c) begin
                            state           <= S_LOAD;
                            write_inst_en   <= 1'b1;
                            busy            <= 1'b1;
                            write_inst_addr <= '0;
                            write_inst_data <= '0;
                            byte_cnt        <= '0;
                            last_idx        <= AW'(in_data - 8'd1);
                        end else begin
                            state      <= S_ERR;
                            load_error <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept_c) begin
                        write_inst_data <= merged_c;
                        if (byte_cnt == BCW'(BPW - 1)) begin
                            state    <= S_COMMIT;
                            in_ready <= 1'b0;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    in_ready <= 1'b1;
                    byte_cnt <= '0;
                    if (write_inst_addr == last_idx) begin
                        state         <= S_IDLE;
                        write_inst_en <= 1'b0;
                        busy          <= 1'b0;
                        load_done     <= 1'b1;
                    end else begin
                        state           <= S_LOAD;
                        write_inst_addr <= write_inst_addr + 1'b1;
                        write_inst_data <= '0;
                    end
                end
                S_ERR: begin
                    in_ready   <= 1'b1;
                    load_error <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: table vectors, directed multi-cycle sequences and random
// sessions checked against a stream-level model of the loader.
module tb_inst_loader;

    localparam int OW  = 25;
    localparam int CNT = 64;
    localparam int BPW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        write_inst_en;
    logic [OW-1:0] write_inst_data;
    logic [5:0]  write_inst_addr;
    logic        busy;
    logic        load_done;
    logic        load_error;

    inst_loader #(.OPCODE_WIDTH(OW), .OPCODE_COUNT(CNT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .write_inst_en(write_inst_en),
        .write_inst_data(write_inst_data), .write_inst_addr(write_inst_addr),
        .busy(busy), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Stimulus words (4 bytes each, little-endian) shared by driver and model.
    logic [7:0] stim [CNT][BPW];

    // Monitor state, written only by the monitor block.
    logic [31:0] mem_seen [CNT];
    int run = 0, last_run = 0, low = 0, last_low = 0;
    int done_cnt = 0, en_total = 0, max_addr = -1;
    int busy_bad = 0, done_bad = 0;
    bit prev_en = 1'b0;
    bit clear_req = 1'b0;

    always @(negedge clk) begin
        if (clear_req) begin
            for (int i = 0; i < CNT; i++) mem_seen[i] = 32'hFFFF_FFFF;
            max_addr = -1;
        end
        if (busy !== write_inst_en) busy_bad++;
        if (load_done) begin
            done_cnt++;
            if (write_inst_en || !prev_en) done_bad++;
        end
        if (write_inst_en) begin
            if (run == 0) last_low = low;
            run++;
            low = 0;
            en_total++;
            mem_seen[write_inst_addr] = 32'(write_inst_data);
            if (int'(write_inst_addr) > max_addr) max_addr = int'(write_inst_addr);
        end else begin
            if (run > 0) last_run = run;
            run = 0;
            low++;
        end
        prev_en = write_inst_en;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Opcode the specification says a 4-byte group should produce.
    function automatic longint ref_word(input int i);
        longint w;
        w = longint'(stim[i][0]) | (longint'(stim[i][1]) << 8) |
            (longint'(stim[i][2]) << 16) | (longint'(stim[i][3]) << 24);
        return w % (longint'(1) << OW);
    endfunction

    task automatic clear_track();
        clear_req = 1'b1;
        @(negedge clk);
        #1;
        clear_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int g);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", guard);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (g) @(negedge clk);
    endtask

    // Sends header + n words; ext = extra enable cycles the gaps add inside the session.
    task automatic send_stream(input int n, input int gmode, output int ext);
        int g;
        int total;
        ext   = 0;
        total = n * BPW;
        for (int j = 0; j <= total; j++) begin
            g = (gmode < 0) ? int'($urandom_range(0, 2)) : gmode;
            if (j == total) g = 0;
            if (j > 0 && ((j - 1) % BPW) == BPW - 1) ext += (g > 0) ? g - 1 : 0;
            else ext += g;
            send_byte((j == 0) ? 8'(n) : stim[(j - 1) / BPW][(j - 1) % BPW], g);
        end
    endtask

    task automatic wait_done(input int target, input string name);
        int guard = 0;
        while (done_cnt < target && guard < 600) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: load_done count %0d, expected %0d", name, done_cnt, target);
        end
    endtask

    task automatic check_session(input string name, input int n, input int exp_run);
        chk({name, "_en_len"}, last_run, exp_run);
        chk({name, "_max_addr"}, max_addr, n - 1);
        for (int i = 0; i < n; i++) begin
            if (mem_seen[i] !== 32'(ref_word(i))) chk({name, "_word"}, mem_seen[i], ref_word(i));
        end
        checks++;
        chk({name, "_busy_eq_en"}, busy_bad, 0);
        chk({name, "_done_edge"}, done_bad, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_outputs", {write_inst_en, busy, load_done, load_error}, 0);
        chk("rst_data_addr", {write_inst_data, write_inst_addr}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", in_ready, 1);
    endtask

    typedef struct {
        logic [7:0]    b0, b1, b2, b3;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t vecs [5];
    int   ext;
    int   base;
    int   en_before;
    int   n;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h78, 8'h56, 8'h34, 8'hFF, 25'h1345678};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 25'h0000000};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 25'h1FFFFFF};
        vecs[3] = '{8'h01, 8'h02, 8'h03, 8'hFE, 25'h0030201};
        vecs[4] = '{8'hAA, 8'h55, 8'hCC, 8'h03, 25'h1CC55AA};

        do_reset();

        // Single-word table vectors: lane assembly and top-byte truncation.
        foreach (vecs[k]) begin
            clear_track();
            base = done_cnt;
            stim[0][0] = vecs[k].b0; stim[0][1] = vecs[k].b1;
            stim[0][2] = vecs[k].b2; stim[0][3] = vecs[k].b3;
            send_stream(1, 0, ext);
            wait_done(base + 1, "vec");
            chk("vec_word", mem_seen[0], 32'(vecs[k].exp));
            chk("vec_en_len", last_run, 5);
            chk("vec_done_once", done_cnt - base, 1);
        end

        // Full buffer back-to-back.
        for (int i = 0; i < CNT; i++) begin
            stim[i][0] = 8'(i);
            stim[i][1] = 8'(i);
            stim[i][2] = 8'(i);
            stim[i][3] = 8'd0;
        end
        clear_track();
        base = done_cnt;
        send_stream(CNT, 0, ext);
        wait_done(base + 1, "full");
        check_session("full", CNT, CNT * (BPW + 1));
        chk("full_word63", mem_seen[63], 32'(63 * 32'h10101));
        chk("full_addr_end", write_inst_addr, 63);

        // Gapped input: 3 idle cycles after every byte.
        for (int i = 0; i < 2; i++)
            for (int b = 0; b < BPW; b++) stim[i][b] = 8'($urandom);
        clear_track();
        base = done_cnt;
        send_stream(2, 3, ext);
        wait_done(base + 1, "gap");
        chk("gap_ext", ext, 23);
        check_session("gap", 2, 10 + ext);

        // Bad headers 0x00 and 0x41.
        for (int t = 0; t < 2; t++) begin
            do_reset();
            base      = done_cnt;
            en_before = en_total;
            send_byte((t == 0) ? 8'h00 : 8'h41, 0);
            for (int j = 0; j < 5; j++) send_byte(8'($urandom), 0);
            chk("bad_error", load_error, 1);
            chk("bad_ready", in_ready, 1);
            chk("bad_en_never", en_total - en_before, 0);
            chk("bad_busy", busy, 0);
            chk("bad_no_done", done_cnt - base, 0);
        end
        do_reset();

        // Reset after 6 data bytes of a 3-word load.
        for (int i = 0; i < 3; i++)
            for (int b = 0; b < BPW; b++) stim[i][b] = 8'($urandom);
        base = done_cnt;
        send_byte(8'd3, 0);
        for (int j = 0; j < 6; j++) send_byte(stim[j / BPW][j % BPW], 0);
        chk("mid_en_before", write_inst_en, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_outputs", {in_ready, write_inst_en, busy, load_done, load_error}, 0);
        chk("mid_data_addr", {write_inst_data, write_inst_addr}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_no_done", done_cnt - base, 0);
        clear_track();
        base = done_cnt;
        send_stream(1, 0, ext);
        wait_done(base + 1, "after_mid");
        check_session("after_mid", 1, 5);

        // Reload: second header lands in the load_done cycle.
        for (int i = 0; i < 2; i++)
            for (int b = 0; b < BPW; b++) stim[i][b] = 8'($urandom);
        clear_track();
        base = done_cnt;
        send_stream(1, 0, ext);
        send_stream(2, 0, ext);
        wait_done(base + 2, "reload");
        chk("reload_done_twice", done_cnt - base, 2);
        chk("reload_low_gap", last_low, 1);
        check_session("reload", 2, 10);

        // Random sessions against the stream model.
        for (int r = 0; r < 20; r++) begin
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++)
                for (int b = 0; b < BPW; b++) stim[i][b] = 8'($urandom);
            clear_track();
            base = done_cnt;
            send_stream(n, ($urandom_range(0, 3) == 0) ? -1 : 0, ext);
            wait_done(base + 1, "rand");
            check_session("rand", n, n * (BPW + 1) + ext);
            chk("rand_done_once", done_cnt - base, 1);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
